bsg_manycore_vcache_wh_link_arbiter: RTL and testbench

Round-robin, packet-atomic arbiter that shares one wormhole ready/valid link among `num_in_p` vcache DMA wormhole streams. It sits between a group of vcaches in a vcache subarray and the single wormhole ruche lane that leaves the subarray edge toward memory. Once a header flit is accepted, the grant is held until the last flit of that packet has passed, so packets are never interleaved. There is no internal buffering: the output is a zero-latency mux of the granted input.

---
 rtl/bsg_manycore_vcache_wh_link_arbiter_pkg.sv | 15 +
 rtl/bsg_manycore_vcache_wh_link_arbiter_rr.sv | 30 +++
 rtl/bsg_manycore_vcache_wh_link_arbiter.sv | 106 ++++++++++
 tb/tb_bsg_manycore_vcache_wh_link_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_vcache_wh_link_arbiter_pkg.sv
// Shared FSM state encoding and index helper for the vcache wormhole link arbiter.
// No logic of its own; imported by the arbiter and its round-robin selector.
package bsg_manycore_vcache_wh_link_arbiter_pkg;

  typedef enum logic {
    e_idle = 1'b0,
    e_busy = 1'b1
  } link_state_e;

  // Successor of idx modulo n, for round-robin pointer advance.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bsg_manycore_vcache_wh_link_arbiter_rr.sv
// Round-robin request picker: first asserted request at or after ptr_i, wrapping.
// Purely combinational (0 cycles); no backpressure, the caller gates with ready.
module bsg_arb_round_robin #(
  parameter int num_in_p    = 4,
  parameter int sel_width_p = 2
) (
  input  logic [num_in_p-1:0]    reqs_i,
  input  logic [sel_width_p-1:0] ptr_i,
  output logic [sel_width_p-1:0] sel_o,
  output logic                   v_o
);

  int idx;

  // Scan from the farthest offset down so the closest request to ptr_i wins last.
  always_comb begin
    sel_o = '0;
    v_o   = 1'b0;
    idx   = 0;
    for (int i = num_in_p - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= num_in_p) idx = idx - num_in_p;
      if (reqs_i[idx]) begin
        sel_o = sel_width_p'(idx);
        v_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_vcache_wh_link_arbiter.sv
// Packet-atomic round-robin mux of vcache DMA wormhole streams onto one link.
// Zero latency, no storage; ready_and_i is routed only to the granted input.
module bsg_manycore_vcache_wh_link_arbiter
  import bsg_manycore_vcache_wh_link_arbiter_pkg::*;
#(
  parameter int num_in_p     = 4,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_in_p-1:0]                    v_i,
  input  logic [num_in_p-1:0][flit_width_p-1:0]  data_i,
  output logic [num_in_p-1:0]                    ready_and_o,
  output logic                                   v_o,
  output logic [flit_width_p-1:0]                data_o,
  input  logic                                   ready_and_i,
  output logic [num_in_p-1:0]                    grant_o,
  output logic                                   busy_o
);

  localparam int sel_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  link_state_e             state_q, state_d;
  logic [sel_width_lp-1:0] sel_q, sel_d;
  logic [sel_width_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [len_width_p-1:0]  count_q, count_d;

  logic [sel_width_lp-1:0] arb_sel;
  logic                    arb_v;
  logic [sel_width_lp-1:0] sel;
  logic                    busy;
  logic                    have_sel;
  logic [num_in_p-1:0]     grant;
  logic [len_width_p-1:0]  hdr_len;
  logic                    xfer;

  bsg_arb_round_robin #(
    .num_in_p    (num_in_p),
    .sel_width_p (sel_width_lp)
  ) rr (
    .reqs_i (v_i),
    .ptr_i  (rr_ptr_q),
    .sel_o  (arb_sel),
    .v_o    (arb_v)
  );

  assign busy     = (state_q == e_busy);
  assign sel      = busy ? sel_q : arb_sel;
  assign have_sel = (busy | arb_v) & ~reset_i;

  always_comb begin
    grant = '0;
    if (have_sel) grant[sel] = 1'b1;
  end

  // v_o depends only on v_i and state, never on ready_and_i.
  assign v_o         = have_sel & v_i[sel];
  assign data_o      = data_i[sel];
  assign ready_and_o = grant & {num_in_p{ready_and_i}};
  assign grant_o     = grant;
  assign busy_o      = busy & ~reset_i;

  assign hdr_len = data_i[sel][cord_width_p +: len_width_p];
  assign xfer    = v_o & ready_and_i;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    if (xfer) begin
      if (!busy) begin
        if (hdr_len == '0) begin
          rr_ptr_d = sel_width_lp'(wrap_inc(int'(sel), num_in_p));
        end else begin
          state_d = e_busy;
          sel_d   = sel;
          count_d = hdr_len;
        end
      end else if (count_q == len_width_p'(1)) begin
        state_d  = e_idle;
        rr_ptr_d = sel_width_lp'(wrap_inc(int'(sel_q), num_in_p));
        count_d  = '0;
      end else begin
        count_d = count_q - len_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_vcache_wh_link_arbiter.sv
// Directed bench for the wormhole link arbiter: vector table plus packet sequences.
// Four inputs, 16-bit flits, cord in [3:0], len in [7:4].
module tb_bsg_manycore_vcache_wh_link_arbiter;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [3:0]       v_i;
  logic [3:0][15:0] data_i;
  logic [3:0]       ready_and_o;
  logic             v_o;
  logic [15:0]      data_o;
  logic             ready_and_i;
  logic [3:0]       grant_o;
  logic             busy_o;

  bsg_manycore_vcache_wh_link_arbiter #(
    .num_in_p     (4),
    .flit_width_p (16),
    .cord_width_p (4),
    .len_width_p  (4)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .ready_and_o (ready_and_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .ready_and_i (ready_and_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic        exp_v;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  logic [15:0] pk [4][20];
  int          pcnt [4];
  int          pidx [4];
  logic [15:0] tdat [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < 4; k++) begin
      pcnt[k] = 0;
      pidx[k] = 0;
    end
  endtask

  task automatic add_pkt(input int k, input int len);
    pk[k][pcnt[k]] = {4'hC, 4'(k), 4'(len), 4'h5};
    pcnt[k]++;
    for (int b = 1; b <= len; b++) begin
      pk[k][pcnt[k]] = 16'hB000 | 16'(k << 8) | 16'(b);
      pcnt[k]++;
    end
  endtask

  task automatic apply_src();
    for (int k = 0; k < 4; k++) begin
      if (pidx[k] < pcnt[k]) begin
        v_i[k]    = 1'b1;
        data_i[k] = pk[k][pidx[k]];
      end else begin
        v_i[k]    = 1'b0;
        data_i[k] = 16'h0000;
      end
    end
  endtask

  // Called mid-cycle: record handshakes, cross the edge, advance the sources.
  task automatic step_src();
    logic [3:0] acc;
    acc = ready_and_o & v_i;
    if (v_o && ready_and_i) n_xfer++;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 4; k++) if (acc[k]) pidx[k]++;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    clear_src();
    v_i = 4'b0000;
    n_xfer = 0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    tdat[0] = 16'hA000; tdat[1] = 16'hA101; tdat[2] = 16'hA202; tdat[3] = 16'hA303;
    //            v        rdy   ev    gnt      rdy_o    data
    tbl[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'h0000};
    tbl[1]  = '{4'b0110, 1'b0, 1'b1, 4'b0010, 4'b0000, 16'hA101};
    tbl[2]  = '{4'b0110, 1'b1, 1'b1, 4'b0010, 4'b0010, 16'hA101};
    tbl[3]  = '{4'b0110, 1'b1, 1'b1, 4'b0100, 4'b0100, 16'hA202};
    tbl[4]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 4'b0001, 16'hA000};
    tbl[5]  = '{4'b1001, 1'b1, 1'b1, 4'b1000, 4'b1000, 16'hA303};
    tbl[6]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0000, 16'hA000};
    tbl[7]  = '{4'b1000, 1'b1, 1'b1, 4'b1000, 4'b1000, 16'hA303};
    tbl[8]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, 16'hA000};
    tbl[9]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 4'b0010, 16'hA101};
    tbl[10] = '{4'b1100, 1'b0, 1'b1, 4'b0100, 4'b0000, 16'hA202};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000};

    clear_src();
    reset_i     = 1'b1;
    v_i         = 4'b1111;
    ready_and_i = 1'b1;
    for (int k = 0; k < 4; k++) data_i[k] = tdat[k];
    #3;
    chk("rst_v_o", 32'(v_o), 32'h0);
    chk("rst_ready_and_o", 32'(ready_and_o), 32'h0);
    chk("rst_grant_o", 32'(grant_o), 32'h0);
    chk("rst_busy_o", 32'(busy_o), 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Single-flit (len 0) headers: selection and pointer rotation in IDLE.
    for (int i = 0; i < 12; i++) begin
      v_i         = tbl[i].v;
      ready_and_i = tbl[i].rdy;
      for (int k = 0; k < 4; k++) data_i[k] = tdat[k];
      #2;
      chk($sformatf("tbl%0d_v_o", i), 32'(v_o), 32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_grant", i), 32'(grant_o), 32'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_ready", i), 32'(ready_and_o), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'h0);
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].exp_data));
      @(posedge clk_i);
      #1;
    end

    // len 0 on input 0 moves the pointer to 1.
    do_reset();
    ready_and_i = 1'b1;
    add_pkt(0, 0);
    apply_src();
    #2;
    chk("s1_v_o", 32'(v_o), 32'h1);
    chk("s1_grant", 32'(grant_o), 32'h1);
    chk("s1_data", 32'(data_o), 32'(pk[0][0]));
    chk("s1_busy", 32'(busy_o), 32'h0);
    step_src();
    chk("s1_busy_after", 32'(busy_o), 32'h0);
    clear_src();
    add_pkt(0, 0);
    add_pkt(1, 0);
    apply_src();
    #2;
    chk("s1_ptr_grant", 32'(grant_o), 32'h2);
    step_src();

    // Inputs 0 and 2, len 3 each: contiguous packets, no bubble between them.
    do_reset();
    ready_and_i = 1'b1;
    add_pkt(0, 3);
    add_pkt(2, 3);
    for (int c = 0; c < 8; c++) begin
      int e;
      e = (c < 4) ? 0 : 2;
      apply_src();
      #2;
      chk($sformatf("s2_c%0d_grant", c), 32'(grant_o), 32'(1 << e));
      chk($sformatf("s2_c%0d_ready", c), 32'(ready_and_o), 32'(1 << e));
      chk($sformatf("s2_c%0d_data", c), 32'(data_o), 32'(pk[e][c % 4]));
      chk($sformatf("s2_c%0d_busy", c), 32'(busy_o), 32'((c % 4) != 0));
      step_src();
    end
    chk("s2_xfers", 32'(n_xfer), 32'd8);

    // Downstream ready toggling across a len 2 packet on input 1.
    do_reset();
    add_pkt(1, 2);
    begin
      logic [4:0] pat;
      int ei;
      pat = 5'b10101;
      ei  = 0;
      for (int c = 0; c < 5; c++) begin
        ready_and_i = pat[c];
        apply_src();
        #2;
        chk($sformatf("s3_c%0d_grant", c), 32'(grant_o), 32'h2);
        chk($sformatf("s3_c%0d_v_o", c), 32'(v_o), 32'h1);
        chk($sformatf("s3_c%0d_data", c), 32'(data_o), 32'(pk[1][ei]));
        step_src();
        if (pat[c]) ei++;
      end
    end
    chk("s3_xfers", 32'(n_xfer), 32'd3);
    chk("s3_busy_after", 32'(busy_o), 32'h0);

    // Fairness: all four inputs with len 1 packets.
    do_reset();
    ready_and_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      add_pkt(k, 1);
      add_pkt(k, 1);
    end
    for (int c = 0; c < 10; c++) begin
      apply_src();
      #2;
      chk($sformatf("s4_c%0d_grant", c), 32'(grant_o), 32'(1 << ((c / 2) % 4)));
      chk($sformatf("s4_c%0d_busy", c), 32'(busy_o), 32'(c % 2));
      step_src();
    end

    // Asynchronous reset with count at 5, then no stale lock.
    do_reset();
    ready_and_i = 1'b1;
    add_pkt(0, 8);
    for (int c = 0; c < 4; c++) begin
      apply_src();
      #2;
      step_src();
    end
    apply_src();
    #2;
    chk("s5_busy_before", 32'(busy_o), 32'h1);
    chk("s5_grant_before", 32'(grant_o), 32'h1);
    reset_i = 1'b1;
    #1;
    chk("s5_rst_v_o", 32'(v_o), 32'h0);
    chk("s5_rst_ready", 32'(ready_and_o), 32'h0);
    chk("s5_rst_grant", 32'(grant_o), 32'h0);
    chk("s5_rst_busy", 32'(busy_o), 32'h0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    clear_src();
    add_pkt(3, 0);
    apply_src();
    #2;
    chk("s5_post_grant", 32'(grant_o), 32'h8);
    chk("s5_post_v_o", 32'(v_o), 32'h1);
    chk("s5_post_ready", 32'(ready_and_o), 32'h8);
    chk("s5_post_busy", 32'(busy_o), 32'h0);
    step_src();

    // Maximum length: 15 body flits after the header.
    do_reset();
    ready_and_i = 1'b1;
    add_pkt(2, 15);
    for (int c = 0; c < 16; c++) begin
      apply_src();
      #2;
      chk($sformatf("s6_c%0d_grant", c), 32'(grant_o), 32'h4);
      chk($sformatf("s6_c%0d_busy", c), 32'(busy_o), 32'(c != 0));
      chk($sformatf("s6_c%0d_data", c), 32'(data_o), 32'(pk[2][c]));
      step_src();
    end
    apply_src();
    #1;
    chk("s6_xfers", 32'(n_xfer), 32'd16);
    chk("s6_busy_after", 32'(busy_o), 32'h0);
    chk("s6_v_o_after", 32'(v_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
